// File: rtl/bin_to_bcd4_pkg.sv
// rtl/bin_to_bcd4_pkg.sv - shared display constants, FSM encoding and clamp helper
package bin_to_bcd4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGITS  = 4;
  localparam int DIGIT_W     = 4;
  localparam int BCD_W       = BCD_DIGITS * DIGIT_W;
  localparam int BIN_W       = 16;
  localparam int MAX_VALUE   = 9999;
  localparam int SHIFT_COUNT = 16;
  localparam int CNT_W       = $clog2(SHIFT_COUNT);

  // Saturating at the display limit keeps every digit within 0..9 through the loop.
  function automatic logic [BIN_W-1:0] clamp_bin(input logic [BIN_W-1:0] v);
    return (v > BIN_W'(MAX_VALUE)) ? BIN_W'(MAX_VALUE) : v;
  endfunction

endpackage

// File: rtl/bin_to_bcd4_bcd_digit_adj.sv
// rtl/bin_to_bcd4_bcd_digit_adj.sv - double-dabble add-3-if-at-least-5 digit correction
module bcd_digit_adj
  import bin_to_bcd4_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= DIGIT_W'(5)) ? i_digit + DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/bin_to_bcd4.sv
// rtl/bin_to_bcd4.sv - sequential 16-bit binary to 4-digit packed BCD converter
module bin_to_bcd4
  import bin_to_bcd4_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [BIN_W-1:0] i_in_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_ovf,
  output logic             o_out_valid
);

  state_t                r_state;
  state_t                w_next;
  logic [BIN_W-1:0]      r_shift;
  logic [BCD_W-1:0]      r_work;
  logic [BCD_W-1:0]      w_adj;
  logic [BCD_W+BIN_W-1:0] w_shifted;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf_next;
  logic [BCD_W-1:0]      r_bcd;
  logic                  r_ovf;
  logic                  r_out_valid;
  logic                  w_accept;
  logic                  w_last_shift;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_work[g*DIGIT_W +: DIGIT_W]),
      .o_digit (w_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign w_shifted    = {w_adj, r_shift} << 1;
  assign w_last_shift = (r_cnt == CNT_W'(SHIFT_COUNT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_in_valid) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last_shift) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (r_state == ST_IDLE);
    w_accept   = o_in_ready & i_in_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_ovf_next  <= 1'b0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_shift    <= clamp_bin(i_in_bin);
        r_work     <= '0;
        r_ovf_next <= (i_in_bin > BIN_W'(MAX_VALUE));
        r_cnt      <= '0;
      end else if (r_state == ST_SHIFT) begin
        {r_work, r_shift} <= w_shifted;
        r_cnt             <= r_cnt + CNT_W'(1);
      end else if (r_state == ST_DONE) begin
        // Outputs only move here so the display never sees a half-built value.
        r_bcd       <= r_work;
        r_ovf       <= r_ovf_next;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign o_bcd       = r_bcd;
  assign o_ovf       = r_ovf;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_bin_to_bcd4.sv
// tb/tb_bin_to_bcd4.sv - scoreboard bench for bin_to_bcd4
module tb_bin_to_bcd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_bin = '0;
  logic        in_ready;
  logic [15:0] bcd;
  logic        ovf;
  logic        out_valid;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  bin_to_bcd4 dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_bin    (in_bin),
    .o_bcd       (bcd),
    .o_ovf       (ovf),
    .o_out_valid (out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int x);
    int v;
    v = (x > 9999) ? 9999 : x;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitor: every out_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic send(input logic [15:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
    exp_t e;
    wait_ready();
    in_valid = 1'b1;
    in_bin   = v;
    @(posedge clk);
    #1;
    e.bcd = exp_bcd;
    e.ovf = exp_ovf;
    e.cyc = cyc + 17;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("drain_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_bcd", 32'(bcd), 32'h0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b1;

    send(16'd1234, 16'h1234, 1'b0);
    drain();

    // Back-to-back: the second is accepted the cycle in_ready rises, 18 cycles after the first.
    send(16'd0, 16'h0000, 1'b0);
    send(16'd9999, 16'h9999, 1'b0);
    drain();

    send(16'd10000, 16'h9999, 1'b1);
    send(16'hFFFF, 16'h9999, 1'b1);
    send(16'd42, 16'h0042, 1'b0);
    drain();

    // in_valid held through SHIFT and DONE with a changing in_bin: only 300 counts.
    begin
      exp_t e;
      wait_ready();
      in_valid = 1'b1;
      in_bin   = 16'd300;
      @(posedge clk);
      #1;
      e.bcd = 16'h0300;
      e.ovf = 1'b0;
      e.cyc = cyc + 17;
      sb.push_back(e);
      for (int k = 0; k < 17; k++) begin
        @(negedge clk);
        in_bin = 16'($urandom);
      end
      @(negedge clk);
      check("ready_after_hold", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      check("hold_single_pulse", 32'(sb.size()), 32'd0);
    end

    send(16'd5678, 16'h5678, 1'b0);
    drain();
    check("bcd_before_abort", 32'(bcd), 32'h5678);

    // Abort at shift 8 of 1111.
    send(16'd1111, 16'h1111, 1'b0);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (out_valid) pulses++;
      end
      check("abort_no_pulse", 32'(pulses), 32'd0);
    end

    for (int k = 0; k < 16; k++) begin
      logic [15:0] x;
      x = (k < 8) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
      send(x, ref_bcd(int'(x)), x > 16'd9999);
    end
    drain();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
